// File: rtl/his_eq_lut_if.sv
// Valid/ready stream carrying the histogram words (total count, then cdf[0..N-1])
// into his_eq_lut.
interface his_eq_lut_if #(
  parameter int C_DATA_WIDTH = 32
);
  logic                    s_valid;
  logic                    s_ready;
  logic [C_DATA_WIDTH-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/his_eq_lut.sv
// Histogram-equalisation LUT: a stream of cumulative counts is turned into a LUT
// in the shadow bank, and pixels are remapped through the active bank.
module his_eq_lut #(
  parameter int C_DATA_WIDTH  = 32,
  parameter int C_VDATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  his_eq_lut_if.slave              hist,
  input  logic                     vs_in,
  input  logic                     hs_in,
  input  logic                     de_in,
  input  logic [C_VDATA_WIDTH-1:0] data_in,
  output logic                     vs_out,
  output logic                     hs_out,
  output logic                     de_out,
  output logic [C_VDATA_WIDTH-1:0] data_out,
  output logic                     lut_valid
);
  localparam int NUM_W = C_DATA_WIDTH + C_VDATA_WIDTH;
  localparam int CNT_W = $clog2(NUM_W);
  localparam int DEPTH = 1 << C_VDATA_WIDTH;
  localparam logic [C_VDATA_WIDTH-1:0] LUT_MAX  = {C_VDATA_WIDTH{1'b1}};
  localparam logic [CNT_W-1:0]         DIV_LAST = CNT_W'(NUM_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_MAX = 3'd1,
    ST_GET_CDF = 3'd2,
    ST_DIV     = 3'd3,
    ST_WRITE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_ready;
  logic   w_xfer;
  logic   w_vs_rise;
  logic   w_swap;

  logic [C_DATA_WIDTH-1:0]  r_max;
  logic [C_DATA_WIDTH-1:0]  r_rem;
  logic [NUM_W-1:0]         r_quo;
  logic [CNT_W-1:0]         r_div_cnt;
  logic [C_VDATA_WIDTH-1:0] r_idx;
  logic                     r_swap_pending;
  logic                     r_active;
  logic                     r_lut_valid;
  logic                     r_vs_prev;

  logic [NUM_W-1:0]          w_prod;
  logic [C_DATA_WIDTH:0]     w_rem_sh;
  logic [C_DATA_WIDTH:0]     w_rem_sub;
  logic                      w_ge;
  logic [C_VDATA_WIDTH-1:0]  w_lut_val;

  logic [C_VDATA_WIDTH-1:0] r_lut [0:2*DEPTH-1];
  logic [C_VDATA_WIDTH-1:0] r_rd;

  logic                     r_vs1, r_hs1, r_de1, r_lv1;
  logic [C_VDATA_WIDTH-1:0] r_px1;
  logic                     r_vs2, r_hs2, r_de2;
  logic [C_VDATA_WIDTH-1:0] r_px2;

  assign hist.s_ready = w_ready & ~reset;
  assign w_xfer       = hist.s_valid & hist.s_ready;
  assign w_vs_rise    = vs_in & ~r_vs_prev;
  assign w_swap       = w_vs_rise & r_swap_pending;

  // One restoring-divide step per DIV cycle; quotient bits shift in from the right.
  assign w_prod    = NUM_W'(hist.s_data) * NUM_W'(LUT_MAX);
  assign w_rem_sh  = {r_rem, r_quo[NUM_W-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_max};
  assign w_ge      = (w_rem_sh >= {1'b0, r_max});
  assign w_lut_val = (r_max == '0) ? r_idx :
                     ((|r_quo[NUM_W-1:C_VDATA_WIDTH]) ? LUT_MAX : r_quo[C_VDATA_WIDTH-1:0]);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_GET_MAX;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and stream ready
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      ST_GET_MAX: begin
        w_ready = 1'b1;
        if (w_xfer) w_state_nxt = ST_GET_CDF;
        else        w_state_nxt = ST_GET_MAX;
      end
      ST_GET_CDF: begin
        w_ready = 1'b1;
        if (w_xfer) w_state_nxt = ST_DIV;
        else        w_state_nxt = ST_GET_CDF;
      end
      ST_DIV: begin
        if (r_div_cnt == DIV_LAST) w_state_nxt = ST_WRITE;
        else                       w_state_nxt = ST_DIV;
      end
      ST_WRITE: begin
        if (r_idx == LUT_MAX) w_state_nxt = ST_IDLE;
        else                  w_state_nxt = ST_GET_CDF;
      end
      ST_IDLE: begin
        if (r_swap_pending) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_GET_MAX;
      end
      default: w_state_nxt = ST_GET_MAX;
    endcase
  end

  // Load datapath, divider and bank-swap control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max          <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_div_cnt      <= '0;
      r_idx          <= '0;
      r_swap_pending <= 1'b0;
      r_active       <= 1'b0;
      r_lut_valid    <= 1'b0;
      r_vs_prev      <= 1'b0;
    end else begin
      r_vs_prev <= vs_in;
      if ((r_state == ST_GET_MAX) && w_xfer) begin
        r_max <= hist.s_data;
        r_idx <= '0;
      end
      if ((r_state == ST_GET_CDF) && w_xfer) begin
        r_quo     <= w_prod;
        r_rem     <= '0;
        r_div_cnt <= '0;
      end
      if (r_state == ST_DIV) begin
        r_rem     <= w_ge ? w_rem_sub[C_DATA_WIDTH-1:0] : w_rem_sh[C_DATA_WIDTH-1:0];
        r_quo     <= {r_quo[NUM_W-2:0], w_ge};
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (r_state == ST_WRITE) r_idx <= r_idx + 1'b1;
      // The pending flag is sampled before this edge, so a load finishing on a vs edge waits a frame.
      if (w_swap) begin
        r_active       <= ~r_active;
        r_swap_pending <= 1'b0;
        r_lut_valid    <= 1'b1;
      end else if ((r_state == ST_WRITE) && (r_idx == LUT_MAX)) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  // LUT storage is deliberately not reset; writes target the shadow bank only
  always_ff @(posedge clk) begin
    if (r_state == ST_WRITE) r_lut[{~r_active, r_idx}] <= w_lut_val;
    r_rd <= r_lut[{r_active, data_in}];
  end

  // Two-stage pixel pipeline keeping syncs aligned with the remapped pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_vs1, r_hs1, r_de1, r_lv1} <= 4'b0000;
      r_px1                        <= '0;
      {r_vs2, r_hs2, r_de2}        <= 3'b000;
      r_px2                        <= '0;
    end else begin
      {r_vs1, r_hs1, r_de1, r_lv1} <= {vs_in, hs_in, de_in, r_lut_valid};
      r_px1                        <= data_in;
      {r_vs2, r_hs2, r_de2}        <= {r_vs1, r_hs1, r_de1};
      r_px2                        <= r_de1 ? (r_lv1 ? r_rd : r_px1) : '0;
    end
  end

  assign vs_out    = r_vs2;
  assign hs_out    = r_hs2;
  assign de_out    = r_de2;
  assign data_out  = r_px2;
  assign lut_valid = r_lut_valid;
endmodule

// File: tb/tb_his_eq_lut.sv
// Randomised bench for his_eq_lut: a cycle-level behavioural model of the load
// protocol and pixel mapping checks every output each cycle, plus literal spot checks.
module tb_his_eq_lut;
  localparam int DW = 32;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vs_in, hs_in, de_in;
  logic [VW-1:0] data_in;
  logic          vs_out, hs_out, de_out, lut_valid;
  logic [VW-1:0] data_out;

  his_eq_lut_if #(.C_DATA_WIDTH(DW)) hist ();

  his_eq_lut #(.C_DATA_WIDTH(DW), .C_VDATA_WIDTH(VW)) dut (
    .clk(clk), .reset(reset), .hist(hist),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .data_in(data_in),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .data_out(data_out),
    .lut_valid(lut_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_xfer = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_cur [0:255];
  logic [7:0] m_new [0:255];
  bit         m_valid = 1'b0, m_pending = 1'b0, m_finish = 1'b0, m_expect_cdf = 1'b0;
  bit         m_vs_prev = 1'b0;
  int         m_busy = 0, m_post = 0, m_idx = 0;
  longint     m_max = 0;
  bit         e_vs1 = 1'b0, e_hs1 = 1'b0, e_de1 = 1'b0, e_vs2 = 1'b0, e_hs2 = 1'b0, e_de2 = 1'b0;
  logic [7:0] e_px1 = 8'h00, e_px2 = 8'h00;

  function automatic logic [7:0] lut_value(input longint cdf, input longint mx, input int idx);
    longint q;
    if (mx == 0) return idx[7:0];
    q = (cdf * 255) / mx;
    if (q > 255) return 8'hFF;
    return q[7:0];
  endfunction

  function automatic bit m_ready();
    return !reset && (m_busy == 0) && !m_pending && !m_finish && (m_post == 0);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("video_out", {vs_out, hs_out, de_out, data_out}, 11'h000);
        chk("lut_valid", lut_valid, 0);
      end else begin
        chk("video_out", {vs_out, hs_out, de_out, data_out}, {e_vs2, e_hs2, e_de2, e_px2});
        chk("lut_valid", lut_valid, m_valid);
      end
      chk("s_ready", hist.s_ready, m_ready());
      if (!reset && hist.s_valid && hist.s_ready) dut_xfer++;

      if (reset) begin
        {e_vs1, e_hs1, e_de1, e_vs2, e_hs2, e_de2} = 6'b0;
        e_px1 = 8'h00; e_px2 = 8'h00;
        m_valid = 1'b0; m_pending = 1'b0; m_finish = 1'b0; m_expect_cdf = 1'b0;
        m_busy = 0; m_post = 0; m_idx = 0; m_vs_prev = 1'b0;
      end else begin
        bit rdy;
        rdy = m_ready();
        e_vs2 = e_vs1; e_hs2 = e_hs1; e_de2 = e_de1;
        e_px2 = e_de1 ? e_px1 : 8'h00;
        e_vs1 = vs_in; e_hs1 = hs_in; e_de1 = de_in;
        e_px1 = m_valid ? m_cur[data_in] : data_in;
        if (m_post > 0) m_post--;
        if (vs_in && !m_vs_prev && m_pending) begin
          m_cur = m_new; m_valid = 1'b1; m_pending = 1'b0; m_post = 1;
        end
        m_vs_prev = vs_in;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0 && m_finish) begin m_finish = 1'b0; m_pending = 1'b1; end
        end
        if (rdy && hist.s_valid) begin
          if (!m_expect_cdf) begin
            m_max = longint'(hist.s_data); m_idx = 0; m_expect_cdf = 1'b1;
          end else begin
            m_new[m_idx] = lut_value(longint'(hist.s_data), m_max, m_idx);
            m_busy = 41;
            if (m_idx == 255) begin m_finish = 1'b1; m_expect_cdf = 1'b0; end
            else m_idx++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] ld [0:256];

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send_words(input int first, input int count);
    logic rdy;
    int   waited;
    for (int k = first; k < first + count; k++) begin
      hist.s_valid = 1'b1;
      hist.s_data  = ld[k];
      waited = 0;
      forever begin
        @(negedge clk); rdy = hist.s_ready;
        @(posedge clk); #2;
        if (rdy) break;
        waited++;
        if (waited > 200) begin
          n_checks++; n_fail++;
          $display("FAIL word_accept_timeout: word %0d not accepted after %0d cycles", k, waited);
          hist.s_valid = 1'b0;
          return;
        end
      end
      if ((k != first + count - 1) && ($urandom_range(0, 3) == 0)) begin
        hist.s_valid = 1'b0;
        step();
      end
    end
    hist.s_valid = 1'b0;
  endtask

  task automatic pix_check(input logic [7:0] px, input logic [7:0] exp, input string name);
    de_in = 1'b1; data_in = px; step();
    de_in = 1'b0; data_in = 8'h00; step();
    chk(name, data_out, exp);
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1; step(); step();
    vs_in = 1'b0; step(); step();
  endtask

  task automatic rand_frame(input int n, input bit rand_vs);
    for (int i = 0; i < n; i++) begin
      vs_in   = rand_vs ? ($urandom_range(0, 15) == 0) : 1'b0;
      hs_in   = (i % 20 == 0);
      de_in   = ($urandom_range(0, 3) != 0);
      data_in = 8'($urandom_range(0, 255));
      step();
    end
    {vs_in, hs_in, de_in} = 3'b000; data_in = 8'h00;
  endtask

  task automatic rand_load();
    longint c;
    ld[0] = DW'($urandom_range(1000, 100000));
    c = 0;
    for (int i = 1; i <= 256; i++) begin
      c = c + $urandom_range(0, 500);
      ld[i] = DW'(c);
    end
  endtask

  initial begin
    int x0;
    reset = 1'b1; {vs_in, hs_in, de_in} = 3'b000; data_in = 8'h00;
    hist.s_valid = 1'b0; hist.s_data = '0;
    repeat (3) step();
    chk("rst_lut_valid", lut_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_s_ready", hist.s_ready, 0);
    reset = 1'b0; #1;
    chk("ready_after_release", hist.s_ready, 1);
    step();

    // Pass-through before any LUT is loaded
    de_in = 1'b1; data_in = 8'h12; step();
    data_in = 8'h80; step();
    de_in = 1'b0; data_in = 8'h00;
    chk("pass_12", data_out, 8'h12);
    step();
    chk("pass_80", data_out, 8'h80);
    chk("pass_lut_valid", lut_valid, 0);

    // Linear load; vs rises on the edge that completes it, so no swap yet
    ld[0] = 32'd256;
    for (int i = 1; i <= 256; i++) ld[i] = DW'(i);
    x0 = dut_xfer;
    send_words(0, 257);
    repeat (40) step();
    vs_in = 1'b1;
    repeat (3) step();
    chk("same_edge_no_swap", lut_valid, 0);
    chk("load_transfers", dut_xfer - x0, 257);
    vs_in = 1'b0; repeat (3) step();
    vs_pulse();
    chk("swap_lut_valid", lut_valid, 1);
    pix_check(8'hFF, 8'hFF, "lin_255");
    pix_check(8'h00, 8'h00, "lin_0");
    pix_check(8'h7F, 8'h7F, "lin_127");

    // Steep load with a clamped entry; completes mid-frame
    ld[0] = 32'd256;
    for (int i = 1; i <= 256; i++) ld[i] = DW'(2 * i);
    ld[11] = 32'd300;
    send_words(0, 257);
    vs_in = 1'b1; step(); step(); vs_in = 1'b0;
    rand_frame(60, 1'b0);
    pix_check(8'h20, 8'h20, "old_lut_mid_frame");
    vs_pulse();
    pix_check(8'h20, 8'h41, "steep_32");
    pix_check(8'h0A, 8'hFF, "clamp_10");
    pix_check(8'hFF, 8'hFF, "steep_255");
    rand_frame(80, 1'b0);

    // max == 0 gives identity
    ld[0] = 32'd0;
    for (int i = 1; i <= 256; i++) ld[i] = DW'($urandom);
    send_words(0, 257);
    repeat (45) step();
    vs_pulse();
    pix_check(8'h5A, 8'h5A, "identity_5a");
    pix_check(8'h20, 8'h20, "identity_20");

    // Reset at idx=100 discards the partial load
    rand_load();
    send_words(0, 101);
    repeat (45) step();
    reset = 1'b1; step(); step();
    chk("midload_rst_lut_valid", lut_valid, 0);
    reset = 1'b0; step();
    pix_check(8'h33, 8'h33, "post_rst_pass");
    rand_load();
    send_words(0, 257);
    repeat (45) step();
    vs_pulse();
    chk("reload_lut_valid", lut_valid, 1);
    rand_frame(200, 1'b1);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/his_eq_lut.md
HIS_EQ_LUT -- requirements
Module: his_eq_lut

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, width of the histogram stream words.
REQ-002 SHALL have parameter C_VDATA_WIDTH, default 8, pixel width; the LUT holds 2^C_VDATA_WIDTH entries (256 at default).
REQ-003 SHALL have port clk, input, 1, clock for all logic.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port s_valid, input, 1, histogram stream word valid.
REQ-006 SHALL have port s_ready, output, 1, block can accept a stream word.
REQ-007 SHALL have port s_data, input, C_DATA_WIDTH, stream word: first word is the total count (max), followed by 256 cumulative counts cdf[0..255].
REQ-008 SHALL have ports vs_in, hs_in, de_in, inputs, 1 each, active-high video syncs and data enable.
REQ-009 SHALL have port data_in, input, C_VDATA_WIDTH, pixel value.
REQ-010 SHALL have ports vs_out, hs_out, de_out, outputs, 1 each, syncs delayed to align with data_out.
REQ-011 SHALL have port data_out, output, C_VDATA_WIDTH, equalized pixel value.
REQ-012 SHALL have port lut_valid, output, 1, high once the first complete LUT is active.

Function
REQ-013 A transfer SHALL occur on a rising clk edge when s_valid and s_ready are both high; no word is accepted in any other cycle.
REQ-014 The FSM SHALL have states IDLE, GET_MAX, GET_CDF, DIV, WRITE; reset state is GET_MAX (IDLE is entered only when a swap is pending, see REQ-021).
REQ-015 GET_MAX: s_ready=1; on transfer, latch s_data as max, clear idx to 0, go to GET_CDF.
REQ-016 GET_CDF: s_ready=1; on transfer, latch s_data as cdf, go to DIV; s_ready SHALL be 0 in DIV, WRITE and IDLE.
REQ-017 DIV SHALL last exactly 40 cycles, running a serial restoring divide that computes q = floor(cdf*255 / max); the numerator is a 40-bit unsigned product.
REQ-018 If q > 255 (cdf > max), the value SHALL be clamped to 255; if max == 0, the value SHALL be idx (identity).
REQ-019 WRITE (1 cycle): write the value to the inactive LUT bank at address idx, then increment idx; if idx was 255 go to IDLE and set swap_pending, else go to GET_CDF.
REQ-020 The LUT SHALL have two banks of 256x8; the active bank serves pixel mapping and the inactive bank receives writes.
REQ-021 IDLE: wait for swap_pending to clear, then go to GET_MAX.
REQ-022 On a rising edge of vs_in (vs_in=1, previous vs_in=0) with swap_pending=1: toggle the active bank, clear swap_pending, and set lut_valid=1 (sticky until reset).
REQ-023 If swap_pending is set in the same cycle as the vs_in rising edge, the swap SHALL wait until the next vs_in rising edge.
REQ-024 Pixel path latency SHALL be exactly 2 cycles for data_out, vs_out, hs_out and de_out alike.
- Cycle 1: registered read of active bank[data_in].
- Cycle 2: output register.
REQ-025 When lut_valid=0, data_out SHALL equal data_in delayed 2 cycles (pass-through).
REQ-026 While de_out=0, data_out SHALL be 0.
REQ-027 The active bank SHALL never change except on a vs_in rising edge, so a frame never mixes two LUTs.
REQ-028 Stream words arriving while s_ready=0 are not lost; the producer holds them under valid/ready.

Reset
REQ-029 On reset:
- FSM goes to GET_MAX; idx=0; swap_pending=0; active bank=0.
- lut_valid=0, s_ready=0 during reset; s_ready=1 in the first cycle after release.
- vs_out=hs_out=de_out=0 and data_out=0.
REQ-030 LUT contents SHALL NOT be reset.
REQ-031 Reset asserted mid-load SHALL discard the partial load; the next word accepted after reset is treated as max.

Verification
REQ-032 Pass-through after reset: de_in pixels 0x12, 0x80 -> data_out 0x12, 0x80 exactly 2 cycles later; lut_valid=0.
REQ-033 Linear load, then swap:
- Stimulus: max=256, cdf[i]=i+1, then one vs_in rising edge.
- Response: LUT[i]=floor((i+1)*255/256); pixel 255 -> 255, pixel 0 -> 0, pixel 127 -> 127; lut_valid=1.
REQ-034 Degenerate cases:
- max=0 -> identity LUT, pixel 0x5A -> 0x5A.
- cdf[10]=300 with max=256 -> LUT[10]=255 (clamp).
REQ-035 Backpressure: s_ready=0 for 41 cycles after each cdf transfer; holding s_valid high loses and duplicates no word; a full load takes 257 transfers.
REQ-036 Swap timing:
- Load completes while a frame is active -> that frame still uses the old LUT; the new LUT applies from the next vs_in rising edge.
- Load completing in the same cycle as the vs_in rising edge -> swap waits one more frame.
REQ-037 Reset at idx=100 -> next accepted word is taken as max; active bank and lut_valid return to reset values.
